pixel_readout_sched: RTL and testbench
======================================

Name: pixel_readout_sched

Overview:
- Frame-level sequencer for N_BANKS pixel-state banks that share one 8-bit AXI-stream output.
- On a start request it triggers each bank in turn and forwards that bank's stream packet to the single master port until tlast.
- After the last bank it holds an inter-frame gap and then reports frame completion.
- Sits between the pixel-state banks and the downstream DMA/stream sink.

Parameters:
- N_BANKS, 4, number of pixel banks sequenced; ≥2.
- DATA_W, 8, tdata width per bank.
- TRIG_LEN, 2, cycles bank_trigger is held high per bank.
- FRAME_GAP, 16, idle cycles after the last bank before frame_done; 0 allowed.
- TIMEOUT, 1024, consecutive cycles without s_valid on the selected bank before that bank is abandoned.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  frame request, sampled in IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- timeout_err  out  N_BANKS  sticky per-bank timeout flags, cleared on start acceptance.
- bank_trigger  out  N_BANKS  one-hot trigger to banks.
- s_valid  in  N_BANKS  bank stream valid.
- s_tlast  in  N_BANKS  bank stream last.
- s_tdata  in  N_BANKS*DATA_W  bank data, bank i at [i*DATA_W +: DATA_W].
- s_ready  out  N_BANKS  bank stream ready.
- m_valid  out  1  master valid.
- m_tlast  out  1  master last.
- m_tdata  out  DATA_W  master data.
- m_tuser  out  clog2(N_BANKS)  index of bank currently forwarded.
- m_ready  in  1  master ready.

Behaviour:
- Reset (rst=0, async):
  - State IDLE, sel=0, all counters 0.
  - busy=0, frame_done=0, timeout_err=0, bank_trigger=0, s_ready=0, m_valid=0, m_tlast=0, m_tdata=0, m_tuser=0.
  - Reset mid-frame discards the frame. No frame_done. A partially transferred packet is not completed.
- States: IDLE, TRIG, STREAM, GAP, DONE.
- IDLE:
  - start=1 → TRIG next cycle, sel=0, timeout_err cleared.
  - start while busy is ignored. No queueing.
- TRIG:
  - bank_trigger[sel]=1 for exactly TRIG_LEN cycles; other bits 0.
  - Then → STREAM.
  - s_valid from the bank during TRIG is not accepted (s_ready=0).
- STREAM:
  - Combinational pass-through of bank sel only: m_valid=s_valid[sel], m_tdata=s_tdata[sel], m_tlast=s_tlast[sel], s_ready[sel]=m_ready. All other s_ready=0.
  - m_tuser=sel. Zero cycles of latency, no buffering.
  - A beat transfers on m_valid&m_ready.
  - On a transfer with m_tlast=1:
    - sel<N_BANKS-1 → sel+1, TRIG.
    - sel=N_BANKS-1 → GAP.
  - Outside STREAM: m_valid=0, m_tlast=0, m_tdata=0 and all s_ready=0.
- Timeout:
  - Counter increments each STREAM cycle with s_valid[sel]=0. It resets on any cycle with s_valid[sel]=1, including when m_ready=0, so backpressure never times out.
  - At count TIMEOUT: set timeout_err[sel]. Advance exactly as for tlast (next bank or GAP).
  - The abandoned bank's later beats are never accepted.
- GAP:
  - FRAME_GAP cycles with all outputs idle, then → DONE.
  - FRAME_GAP=0 → DONE directly after the last tlast cycle.
- DONE:
  - frame_done=1 for one cycle → IDLE.
  - busy drops in the IDLE cycle that follows DONE.
  - start is first sampled in IDLE, so the minimum spacing between frames is 1 IDLE cycle.
- Simultaneous events:
  - A tlast transfer in the same cycle the timeout count reaches TIMEOUT: the tlast wins and no error is flagged. This cannot happen in practice because s_valid=1 resets the counter; it is stated for completeness.
- Counter widths:
  - Trigger counter clog2(TRIG_LEN+1), gap counter clog2(FRAME_GAP+1), timeout counter clog2(TIMEOUT+1).
  - No wrap-around: counters saturate at their terminal value.

Test Plan:
- Basic frame, N_BANKS=4, TRIG_LEN=2, m_ready=1. Each bank returns 3 beats (0xA0+i, 0xB0+i, 0xC0+i with tlast).
  - m_tdata sequence is the 12 bytes in bank order, with m_tuser=0,0,0,1,1,1,…
  - Each bank_trigger bit pulses for 2 cycles, in order.
  - frame_done pulses once, FRAME_GAP+1 cycles after the 12th beat. timeout_err=0.
- Backpressure: m_ready toggles every cycle, as in the pixel-state bench's ready toggle, with banks holding valid.
  - No beat is lost or duplicated. s_ready[sel] mirrors m_ready.
  - No timeout, even with TIMEOUT=4.
- Dead bank: TIMEOUT=8, bank 2 never asserts valid.
  - After 8 STREAM cycles timeout_err=4'b0100 and bank 3 is triggered.
  - The frame completes with 9 beats. The flag clears on the next accepted start.
- Reset mid-operation: drop rst after beat 1 of bank 1.
  - All outputs at reset values the same instant.
  - No frame_done follows. A new start gives a full, correct frame.
- Start handling: start held high continuously.
  - Back-to-back frames with exactly 1 IDLE cycle between DONE and the next TRIG.
  - A start pulse during STREAM has no effect.
- Isolation: unselected banks assert s_valid with tlast throughout.
  - Their s_ready stays 0 and their data never appears on m_tdata.

Source files
------------

// File: rtl/pixel_readout_sched.sv
// Frame sequencer: triggers each pixel bank in turn and forwards its packet to one stream port.
// Zero-latency pass-through while streaming; a bank silent for TIMEOUT cycles is flagged and skipped.
module pixel_readout_sched #(
  parameter int N_BANKS   = 4,
  parameter int DATA_W    = 8,
  parameter int TRIG_LEN  = 2,
  parameter int FRAME_GAP = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        frame_done,
  output logic [N_BANKS-1:0]          timeout_err,
  output logic [N_BANKS-1:0]          bank_trigger,
  input  logic [N_BANKS-1:0]          s_valid,
  input  logic [N_BANKS-1:0]          s_tlast,
  input  logic [N_BANKS*DATA_W-1:0]   s_tdata,
  output logic [N_BANKS-1:0]          s_ready,
  output logic                        m_valid,
  output logic                        m_tlast,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [$clog2(N_BANKS)-1:0]  m_tuser,
  input  logic                        m_ready
);
  localparam int SW = $clog2(N_BANKS);
  localparam int TW = $clog2(TRIG_LEN + 1);
  localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TRIG_END  = TW'(TRIG_LEN - 1);
  localparam logic [TW-1:0] TRIG_MAX  = TW'(TRIG_LEN);
  localparam logic [GW-1:0] GAP_END   = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;
  localparam logic [GW-1:0] GAP_MAX   = (FRAME_GAP > 0) ? GW'(FRAME_GAP) : '0;
  localparam logic [OW-1:0] TO_END    = OW'(TIMEOUT - 1);
  localparam logic [OW-1:0] TO_MAX    = OW'(TIMEOUT);
  localparam logic [SW-1:0] LAST_BANK = SW'(N_BANKS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, STREAM, GAP, DONE} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      sel, sel_nx;
  logic [N_BANKS-1:0] err_nx;
  logic [TW-1:0]      trig_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [OW-1:0]      to_cnt;
  logic               sel_valid, last_xfer, to_hit;

  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    err_nx       = timeout_err;
    busy         = (state != IDLE);
    frame_done   = 1'b0;
    bank_trigger = '0;
    s_ready      = '0;
    m_valid      = 1'b0;
    m_tlast      = 1'b0;
    m_tdata      = '0;
    m_tuser      = '0;
    sel_valid    = s_valid[sel];
    last_xfer    = (state == STREAM) && sel_valid && m_ready && s_tlast[sel];
    // Only reachable with valid low, so a tlast transfer always takes precedence.
    to_hit       = (state == STREAM) && !sel_valid && (to_cnt == TO_END);
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = TRIG;
          sel_nx   = '0;
          err_nx   = '0;
        end
      end
      TRIG: begin
        bank_trigger[sel] = 1'b1;
        if (trig_cnt == TRIG_END) state_nx = STREAM;
      end
      STREAM: begin
        m_valid      = sel_valid;
        m_tlast      = s_tlast[sel];
        m_tdata      = s_tdata[sel*DATA_W +: DATA_W];
        m_tuser      = sel;
        s_ready[sel] = m_ready;
        if (last_xfer || to_hit) begin
          if (to_hit) err_nx[sel] = 1'b1;
          if (sel == LAST_BANK) begin
            state_nx = (FRAME_GAP == 0) ? DONE : GAP;
          end else begin
            sel_nx   = sel + SW'(1);
            state_nx = TRIG;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sel         <= '0;
      timeout_err <= '0;
      trig_cnt    <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      timeout_err <= err_nx;
      if (state == TRIG && state_nx == TRIG) begin
        if (trig_cnt != TRIG_MAX) trig_cnt <= trig_cnt + TW'(1);
      end else begin
        trig_cnt <= '0;
      end
      if (state == GAP && state_nx == GAP) begin
        if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
      // Any valid cycle restarts the silence count, so backpressure can never time out.
      if (state == STREAM && state_nx == STREAM && !sel_valid) begin
        if (to_cnt != TO_MAX) to_cnt <= to_cnt + OW'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_readout_sched.sv
// Bench for pixel_readout_sched: scenario table, reset-abort sequence and randomized frames,
// each frame checked against a packet-level model of the expected output stream.
module tb_pixel_readout_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TL = 2;
  localparam int FG = 3;
  localparam int TO = 8;
  localparam int UW = $clog2(N);

  typedef struct packed {
    logic [UW-1:0] bank;
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N-1:0] dead;
    int           rdy;
    bit           iso;
    bit           hold;
    bit           noise;
    logic [N-1:0] exp_err;
    int           exp_beats;
  } row_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy, frame_done;
  logic [N-1:0]    timeout_err, bank_trigger, s_ready;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic            m_valid, m_tlast;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic [UW-1:0]   m_tuser;

  int            n_cmp = 0;
  int            n_bad = 0;
  beat_t         exp_q[$];
  int            pkt_len [N];
  int            pkt_pos [N];
  logic [DW-1:0] pkt_dat [N][8];
  row_t          rows [8];

  always #5 clk = ~clk;

  pixel_readout_sched #(
    .N_BANKS(N), .DATA_W(DW), .TRIG_LEN(TL), .FRAME_GAP(FG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .bank_trigger(bank_trigger), .s_valid(s_valid),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .s_ready(s_ready), .m_valid(m_valid),
    .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tuser(m_tuser), .m_ready(m_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One frame from the IDLE cycle that samples start up to the frame_done cycle.
  // rdy: 0 = always ready, 1 = toggle, 2 = random (banks also drop valid briefly).
  task automatic run_frame(input logic [N-1:0] dead, input int rdy, input bit iso, input bit hold,
                           input bit rnd, input bit noise, input int abort_at,
                           output int beats, output logic [N-1:0] err_seen);
    int           trig_cnt [N];
    int           trig_first [N];
    int           trig_last [N];
    int           idle_run [N];
    logic [N-1:0] armed, mask;
    int           active, n_exp, last_beat_c, done_c;
    bit           done_seen, stop, accepted;
    beat_t        got, want;
    exp_q.delete();
    armed = '0; active = -1; done_seen = 1'b0; stop = 1'b0;
    last_beat_c = -1; done_c = -1; beats = 0; err_seen = '0;
    for (int b = 0; b < N; b++) begin
      trig_cnt[b] = 0; trig_first[b] = -1; trig_last[b] = -1; idle_run[b] = 0; pkt_pos[b] = 0;
      pkt_len[b] = rnd ? int'($urandom_range(1, 6)) : 3;
      for (int k = 0; k < pkt_len[b]; k++) begin
        pkt_dat[b][k] = rnd ? 8'($urandom_range(0, 255)) : 8'(8'hA0 + 16 * k + b);
        if (!dead[b]) exp_q.push_back('{bank: UW'(b), dat: pkt_dat[b][k], last: (k == pkt_len[b] - 1)});
      end
    end
    n_exp = exp_q.size();
    for (int c = 0; c < 400 && !done_seen && !stop; c++) begin
      @(negedge clk);
      start = (c == 0) || hold || (noise && c > 0 && $urandom_range(0, 3) == 0);
      case (rdy)
        0:       m_ready = 1'b1;
        1:       m_ready = c[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      for (int b = 0; b < N; b++) begin
        if (armed[b] && b == active) begin
          s_valid[b] = 1'b0; s_tlast[b] = 1'b0; s_tdata[b*DW +: DW] = '0;
          if (!dead[b] && pkt_pos[b] < pkt_len[b]) begin
            if (rdy == 2 && idle_run[b] < 2 && $urandom_range(0, 2) == 0) begin
              idle_run[b]++;
            end else begin
              idle_run[b] = 0;
              s_valid[b] = 1'b1;
              s_tlast[b] = (pkt_pos[b] == pkt_len[b] - 1);
              s_tdata[b*DW +: DW] = pkt_dat[b][pkt_pos[b]];
            end
          end
        end else begin
          s_valid[b] = iso; s_tlast[b] = iso; s_tdata[b*DW +: DW] = iso ? 8'hEE : 8'h00;
        end
      end
      #1;
      if (c == 0) begin
        check("idle_before_start", 32'(busy), 32'(0));
        check("no_done_in_idle", 32'(frame_done), 32'(0));
      end else begin
        check("busy", 32'(busy), 32'(1));
      end
      if (c == 1) check("trig_after_start", 32'(bank_trigger), 32'(1));
      check("trig_onehot", 32'($onehot0(bank_trigger)), 32'(1));
      if (bank_trigger != '0) check("no_ready_in_trig", 32'(s_ready), 32'(0));
      for (int b = 0; b < N; b++) begin
        if (bank_trigger[b]) begin
          if (trig_cnt[b] == 0) begin
            trig_first[b] = c;
            if (b == 0) begin
              check("err_cleared", 32'(timeout_err), 32'(0));
            end else if (dead[b-1]) begin
              check("dead_stream_cycles", 32'(c - trig_last[b-1] - 1), 32'(TO));
              check("err_flag_set", 32'(timeout_err[b-1]), 32'(1));
            end else begin
              check("trig_after_tlast", 32'(c - last_beat_c), 32'(1));
            end
          end
          trig_cnt[b]++; trig_last[b] = c; armed[b] = 1'b1; active = b;
        end
      end
      mask = '0;
      accepted = 1'b0;
      if (active >= 0) begin
        mask[active] = 1'b1;
        accepted = s_ready[active] && s_valid[active];
      end
      check("s_ready_isolation", 32'(s_ready & ~mask), 32'(0));
      if (m_valid && m_ready) begin
        beats++; last_beat_c = c;
        got  = '{bank: m_tuser, dat: m_tdata, last: m_tlast};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("beat", 32'(got), 32'(want));
        check("beat_from_bank", 32'(accepted), 32'(1));
      end
      if (accepted) pkt_pos[active]++;
      if (frame_done) begin
        done_seen = 1'b1; done_c = c; err_seen = timeout_err;
        check("idle_outputs_at_done", 32'({m_valid, m_tdata, s_ready, bank_trigger}), 32'(0));
      end
      if (abort_at >= 0 && beats == abort_at) stop = 1'b1;
    end
    if (!stop) begin
      check("frame_done_seen", 32'(done_seen), 32'(1));
      check("beat_count", 32'(beats), 32'(n_exp));
      for (int b = 0; b < N; b++) check("trig_len", 32'(trig_cnt[b]), 32'(TL));
      if (!dead[N-1]) check("done_latency", 32'(done_c - last_beat_c), 32'(FG + 1));
      check("err_mask", 32'(err_seen), 32'(dead));
    end
  endtask

  initial begin
    int           beats;
    logic [N-1:0] err, dead;
    rows[0] = '{4'b0000, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 12};  // basic
    rows[1] = '{4'b0000, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 12};  // ready toggling
    rows[2] = '{4'b0100, 0, 1'b0, 1'b0, 1'b0, 4'b0100, 9};   // dead middle bank
    rows[3] = '{4'b0000, 0, 1'b1, 1'b0, 1'b1, 4'b0000, 12};  // isolation + stray start
    rows[4] = '{4'b0000, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 12};  // start held
    rows[5] = '{4'b0000, 1, 1'b0, 1'b1, 1'b0, 4'b0000, 12};  // back-to-back
    rows[6] = '{4'b1000, 1, 1'b1, 1'b0, 1'b0, 4'b1000, 9};   // dead last bank
    rows[7] = '{4'b0001, 0, 1'b1, 1'b0, 1'b1, 4'b0001, 9};   // dead first bank

    s_valid = '1; s_tlast = '1; s_tdata = '1; m_ready = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", 32'({busy, frame_done, timeout_err, bank_trigger, s_ready,
                                m_valid, m_tlast, m_tdata, m_tuser}), 32'(0));
    @(negedge clk);
    start = 1'b0; s_valid = '0; s_tlast = '0; s_tdata = '0; rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(rows[i].dead, rows[i].rdy, rows[i].iso, rows[i].hold, 1'b0, rows[i].noise, -1, beats, err);
      check("row_beats", 32'(beats), 32'(rows[i].exp_beats));
      check("row_err", 32'(err), 32'(rows[i].exp_err));
    end

    // Abort after the first beat of bank 1 has transferred.
    run_frame(4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4, beats, err);
    check("abort_point", 32'(beats), 32'(4));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({busy, frame_done, timeout_err, bank_trigger, s_ready,
                                         m_valid, m_tlast, m_tdata, m_tuser}), 32'(0));
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("no_done_after_reset", 32'({frame_done, busy}), 32'(0));
    end
    run_frame(4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1, beats, err);
    check("frame_after_reset", 32'(beats), 32'(12));

    for (int i = 0; i < 20; i++) begin
      dead = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      run_frame(dead, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                1'($urandom_range(0, 1)), -1, beats, err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
